// File: rtl/riscv_csr_counters_pkg.sv
// riscv_csr_counters_pkg: CSR addresses, op encoding and the read-modify-write ALU
package riscv_csr_counters_pkg;
    localparam logic [11:0] CSR_ADDR_MCYCLE         = 12'hB00;
    localparam logic [11:0] CSR_ADDR_MCYCLEH        = 12'hB80;
    localparam logic [11:0] CSR_ADDR_MINSTRET       = 12'hB02;
    localparam logic [11:0] CSR_ADDR_MINSTRETH      = 12'hB82;
    localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3   = 12'hB03;
    localparam logic [11:0] CSR_ADDR_MHPMCOUNTER3H  = 12'hB83;
    localparam logic [11:0] CSR_ADDR_MHPMEVENT3     = 12'h323;
    localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT  = 12'h320;
    localparam int CSR_OP_T_WIDTH = 2;
    typedef enum logic [CSR_OP_T_WIDTH-1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_t;
    function automatic logic [31:0] csr_alu(csr_op_t op, logic [31:0] old, logic [31:0] wdata);
        return op == CSR_OP_WRITE ? wdata :
               op == CSR_OP_SET   ? old | wdata :
               op == CSR_OP_CLEAR ? old & ~wdata : old;
    endfunction
    // bank slot i holds mcycle (0), minstret (2), then mhpmcounter3.. in order
    function automatic logic [4:0] cnt_num(int i);
        return 5'(i == 0 ? 0 : i == 1 ? 2 : i + 1);
    endfunction
endpackage

// File: rtl/riscv_split_counter.sv
// riscv_split_counter: CNT_W-bit counter with independently writable 32-bit halves
module riscv_split_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] cnt
);
    localparam int HW = CNT_W - 32;
    logic [31:0]   lo;
    logic [HW-1:0] hi;
    assign cnt = {hi, lo};
    // a low-half write swallows the carry; a high-half write drops it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= wr_lo ? wdata : lo + 32'(inc);
            hi <= wr_hi ? wdata[HW-1:0] : hi + HW'(!wr_lo && inc && &lo);
        end
    end
endmodule

// File: rtl/riscv_csr_counters.sv
// riscv_csr_counters: machine-mode cycle/instret/HPM counter bank with CSR RMW access
module riscv_csr_counters
    import riscv_csr_counters_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  csr_valid_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [1:0]            csr_op_i,
    input  logic [31:0]           csr_wdata_i,
    input  logic                  instr_retired_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    output logic                  csr_rvalid_o,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_illegal_o
);
    localparam int NC = NUM_HPM + 2;
    localparam int NH = NUM_HPM > 0 ? NUM_HPM : 1;
    localparam int EW = $clog2(NUM_EVENTS + 1);
    localparam logic [31:0] INH_MASK = 32'((64'd1 << (3 + NUM_HPM)) - 64'd1) & 32'hFFFF_FFFD;
    logic [CNT_W-1:0] cnt [NC];
    logic [NC-1:0]    inc, wr_lo, wr_hi;
    logic [EW-1:0]    hpm_event [NH];
    logic [31:0]      inhibit, old_val, new_val;
    logic [4:0]       n;
    logic             is_lo, is_hi, is_evt, is_inh, legal, wr;
    assign n       = csr_addr_i[4:0];
    assign is_lo   = csr_addr_i[11:5] == CSR_ADDR_MCYCLE[11:5] && n != 5'd1;
    assign is_hi   = csr_addr_i[11:5] == CSR_ADDR_MCYCLEH[11:5] && n != 5'd1;
    assign is_evt  = csr_addr_i[11:5] == CSR_ADDR_MHPMEVENT3[11:5] && n >= 5'd3;
    assign is_inh  = csr_addr_i == CSR_ADDR_MCOUNTINHIBIT;
    assign legal   = is_lo || is_hi || is_evt || is_inh;
    assign wr      = csr_valid_i && legal && csr_op_i != CSR_OP_READ;
    assign new_val = csr_alu(csr_op_t'(csr_op_i), old_val, csr_wdata_i);
    // unimplemented HPM slots fall through every match and read 0
    always_comb begin
        old_val = '0;
        for (int i = 0; i < NC; i++)
            if ((is_lo || is_hi) && n == cnt_num(i))
                old_val = is_hi ? 32'(cnt[i][CNT_W-1:32]) : cnt[i][31:0];
        for (int j = 0; j < NUM_HPM; j++)
            if (is_evt && n == 5'(j + 3))
                old_val = 32'(hpm_event[j]);
        if (is_inh)
            old_val = inhibit;
    end
    always_comb begin
        inc   = '0;
        wr_lo = '0;
        wr_hi = '0;
        for (int i = 0; i < NC; i++) begin
            wr_lo[i] = wr && is_lo && n == cnt_num(i);
            wr_hi[i] = wr && is_hi && n == cnt_num(i);
        end
        inc[0] = !inhibit[0];
        inc[1] = instr_retired_i && !inhibit[2];
        for (int j = 0; j < NUM_HPM; j++) begin
            for (int e = 1; e <= NUM_EVENTS; e++)
                inc[j+2] = inc[j+2] | (hpm_event[j] == EW'(e) && events_i[e-1]);
            inc[j+2] = inc[j+2] && !inhibit[j+3];
        end
    end
    for (genvar i = 0; i < NC; i++) begin : g_cnt
        riscv_split_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc    (inc[i]),
            .wr_lo  (wr_lo[i]),
            .wr_hi  (wr_hi[i]),
            .wdata  (new_val),
            .cnt    (cnt[i])
        );
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inhibit       <= '0;
            csr_rvalid_o  <= 1'b0;
            csr_rdata_o   <= '0;
            csr_illegal_o <= 1'b0;
            for (int j = 0; j < NH; j++)
                hpm_event[j] <= '0;
        end else begin
            if (wr && is_inh)
                inhibit <= new_val & INH_MASK;
            for (int j = 0; j < NUM_HPM; j++)
                if (wr && is_evt && n == 5'(j + 3))
                    hpm_event[j] <= new_val <= 32'(NUM_EVENTS) ? EW'(new_val) : '0;
            csr_rvalid_o  <= csr_valid_i;
            csr_rdata_o   <= csr_valid_i ? old_val : '0;
            csr_illegal_o <= csr_valid_i && !legal;
        end
    end
endmodule

// File: tb/tb_riscv_csr_counters.sv
// tb_riscv_csr_counters: random and directed CSR traffic checked against a behavioural model
module tb_riscv_csr_counters;
    localparam int NUM_HPM = 4;
    localparam int NUM_EVENTS = 8;
    localparam int CNT_W = 64;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        csr_valid_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [1:0]  csr_op_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic        instr_retired_i = 1'b0;
    logic [7:0]  events_i = '0;
    logic        csr_rvalid_o;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    int checks = 0;
    int failures = 0;
    longint unsigned mc [32];
    int unsigned     mev [32];
    logic [31:0]     minh;

    riscv_csr_counters #(.NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .csr_valid_i     (csr_valid_i),
        .csr_addr_i      (csr_addr_i),
        .csr_op_i        (csr_op_i),
        .csr_wdata_i     (csr_wdata_i),
        .instr_retired_i (instr_retired_i),
        .events_i        (events_i),
        .csr_rvalid_o    (csr_rvalid_o),
        .csr_rdata_o     (csr_rdata_o),
        .csr_illegal_o   (csr_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit impl(input int k);
        return k == 0 || k == 2 || (k >= 3 && k < 3 + NUM_HPM);
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 32; k++) begin
            mc[k] = 0;
            mev[k] = 0;
        end
        minh = 0;
    endfunction

    function automatic bit m_read(input logic [11:0] a, output logic [31:0] v);
        int k;
        v = 0;
        if (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) begin
            k = int'(a - 12'hB00);
            if (impl(k)) v = mc[k][31:0];
            return 1;
        end
        if (a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) begin
            k = int'(a - 12'hB80);
            if (impl(k)) v = mc[k][63:32];
            return 1;
        end
        if (a == 12'h320) begin
            v = minh;
            return 1;
        end
        if (a >= 12'h323 && a <= 12'h33F) begin
            k = int'(a - 12'h320);
            if (impl(k)) v = mev[k];
            return 1;
        end
        return 0;
    endfunction

    function automatic void m_update(input bit v, input logic [11:0] a, input logic [1:0] op,
                                     input logic [31:0] w, input bit ret, input logic [7:0] evs);
        longint unsigned incv [32];
        logic [31:0] old, nv;
        bit legal;
        int k;
        legal = m_read(a, old);
        nv = op == 2'd1 ? w : op == 2'd2 ? (old | w) : op == 2'd3 ? (old & ~w) : old;
        for (int i = 0; i < 32; i++) incv[i] = 0;
        incv[0] = minh[0] ? 0 : 1;
        incv[2] = (ret && !minh[2]) ? 1 : 0;
        for (int i = 3; i < 3 + NUM_HPM; i++)
            incv[i] = (!minh[i] && mev[i] != 0 && evs[mev[i]-1]) ? 1 : 0;
        if (v && legal && op != 2'd0) begin
            if (a >= 12'hB00 && a <= 12'hB1F) begin
                k = int'(a - 12'hB00);
                if (impl(k)) begin
                    mc[k] = {mc[k][63:32], nv};
                    incv[k] = 0;
                end
            end else if (a >= 12'hB80 && a <= 12'hB9F) begin
                k = int'(a - 12'hB80);
                if (impl(k)) begin
                    mc[k] = {nv, 32'(mc[k][31:0] + incv[k])};
                    incv[k] = 0;
                end
            end else if (a == 12'h320) begin
                minh = nv & 32'h7D;
            end else begin
                k = int'(a - 12'h320);
                if (impl(k)) mev[k] = nv <= NUM_EVENTS ? nv : 0;
            end
        end
        for (int i = 0; i < 32; i++)
            if (impl(i)) mc[i] += incv[i];
    endfunction

    task automatic step(input bit v, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] w, input bit ret, input logic [7:0] evs);
        logic [31:0] rv;
        bit legal;
        csr_valid_i = v;
        csr_addr_i = a;
        csr_op_i = op;
        csr_wdata_i = w;
        instr_retired_i = ret;
        events_i = evs;
        legal = m_read(a, rv);
        m_update(v, a, op, w, ret, evs);
        @(posedge clk_i);
        #1;
        check("rvalid", 32'(csr_rvalid_o), 32'(v));
        if (v) begin
            check("rdata", csr_rdata_o, legal ? rv : 32'h0);
            check("illegal", 32'(csr_illegal_o), 32'(!legal));
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 12'h000, 2'd0, 0, 0, 8'h00);
    endtask

    task automatic rd(input logic [11:0] a);
        step(1, a, 2'd0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        csr_valid_i = 1'b0;
        #1;
        check("rst_rvalid", 32'(csr_rvalid_o), 0);
        check("rst_rdata", csr_rdata_o, 0);
        check("rst_illegal", 32'(csr_illegal_o), 0);
        m_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    function automatic logic [11:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        return r == 0 ? 12'hB00 : r == 1 ? 12'hB80 : r == 2 ? 12'hB02 : r == 3 ? 12'hB82 :
               r == 4 ? 12'(12'hB03 + $urandom_range(0, 4)) : r == 5 ? 12'(12'hB83 + $urandom_range(0, 4)) :
               r == 6 ? 12'h320 : r == 7 ? 12'(12'h323 + $urandom_range(0, 4)) :
               r == 8 ? 12'hB1F : r == 9 ? 12'hB9F : r == 10 ? 12'h33F : r == 11 ? 12'h7C0 :
               r == 12 ? 12'hB01 : r == 13 ? 12'h321 : r == 14 ? 12'(12'hB03 + $urandom_range(0, 4)) :
               12'(12'h323 + $urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] pick_data();
        int unsigned r;
        r = $urandom_range(0, 3);
        return r == 0 ? 32'($urandom) : r == 1 ? 32'($urandom_range(0, 10)) :
               r == 2 ? 32'hFFFF_FFFF : 32'h1 << $urandom_range(0, 31);
    endfunction

    initial begin
        m_reset();
        #1;
        check("init_rvalid", 32'(csr_rvalid_o), 0);
        check("init_rdata", csr_rdata_o, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(10);
        rd(12'hB00);
        check("idle_cycle", csr_rdata_o, 10);
        rd(12'hB80);
        check("idle_cycle_hi", csr_rdata_o, 0);
        check("idle_illegal", 32'(csr_illegal_o), 0);
        step(1, 12'hB00, 2'd1, 32'hFFFF_FFFF, 0, 8'h00);
        idle(1);
        rd(12'hB80);
        check("wrap_hi", csr_rdata_o, 1);
        step(1, 12'hB00, 2'd1, 32'hFFFF_FFFF, 0, 8'h00);
        step(1, 12'hB80, 2'd1, 32'h0000_0055, 0, 8'h00);
        rd(12'hB80);
        check("hi_wr_collide", csr_rdata_o, 32'h55);
        step(1, 12'h320, 2'd2, 32'h5, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 12'hB00, 2'd0, 0, 1, 8'h00);
        rd(12'hB02);
        step(1, 12'h320, 2'd3, 32'h1, 1, 8'h00);
        idle(3);
        rd(12'hB00);
        step(1, 12'h323, 2'd1, 32'h2, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 12'h000, 2'd0, 0, 0, 8'h02);
        for (int i = 0; i < 3; i++) step(0, 12'h000, 2'd0, 0, 0, 8'h01);
        rd(12'hB03);
        check("hpm_evt_count", csr_rdata_o, 7);
        step(1, 12'h323, 2'd1, 32'h3F, 0, 8'h00);
        rd(12'h323);
        check("evt_warl", csr_rdata_o, 0);
        rd(12'h7C0);
        check("bad_illegal", 32'(csr_illegal_o), 1);
        check("bad_rdata", csr_rdata_o, 0);
        rd(12'hB1F);
        check("unimpl_illegal", 32'(csr_illegal_o), 0);
        check("unimpl_rdata", csr_rdata_o, 0);
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                step(1, 12'hB00, 2'd0, 0, 1, 8'hFF);
                do_reset();
                rd(12'hB80);
                check("post_rst_hi", csr_rdata_o, 0);
                rd(12'h320);
                check("post_rst_inh", csr_rdata_o, 0);
                rd(12'h324);
                check("post_rst_evt", csr_rdata_o, 0);
                rd(12'hB03);
                check("post_rst_hpm", csr_rdata_o, 0);
            end
            step($urandom_range(0, 3) != 0, pick_addr(), 2'($urandom_range(0, 3)), pick_data(),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_csr_counters.md
# riscv_csr_counters

Parametrised machine-mode counter unit for the dtcore32 CSR path. It holds `mcycle`, `minstret`, `mcountinhibit` and a configurable bank of `mhpmcounterN`/`mhpmeventN` pairs, each fed from a vector of core event strobes. CSR read-modify-write requests arrive from the execute-stage CSR decoder. Read data and illegal flags return one cycle later. The block replaces fixed 64-bit cycle/instret registers with a generalised, width- and count-parametrised bank.

## Interface
- `NUM_HPM`, default 4: implemented HPM counters, indices 3..3+NUM_HPM-1. Legal range 0..29.
- `NUM_EVENTS`, default 8: width of `events_i`. Minimum 1.
- `CNT_W`, default 64: counter width. Legal range 33..64.
- `clk_i` in 1: the block's single clock.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `csr_valid_i` in 1: CSR access request this cycle.
- `csr_addr_i` in 12: CSR address.
- `csr_op_i` in 2: 00 read, 01 write, 10 set, 11 clear.
- `csr_wdata_i` in 32: write value or bitmask.
- `instr_retired_i` in 1: one instruction retired this cycle.
- `events_i` in NUM_EVENTS: per-cycle event strobes.
- `csr_rvalid_o` out 1: response valid.
- `csr_rdata_o` out 32: old CSR value.
- `csr_illegal_o` out 1: address not decoded. Qualified by `csr_rvalid_o`.

## Operation
- Address map:
  - `mcycle` B00/B80.
  - `minstret` B02/B82.
  - `mhpmcounter3..31` B03..B1F, with high halves B83..B9F.
  - `mhpmevent3..31` 323..33F.
  - `mcountinhibit` 320.
  - Any other address sets `csr_illegal_o`. In that case there is no state change and rdata is 0.
- Unimplemented HPM indices (≥3+NUM_HPM) are legal. They read 0 and ignore writes.
- New value: write gives wdata. Set gives old | wdata. Clear gives old & ~wdata. Read changes nothing.
- Counters:
  - Full CNT_W bits, wrapping at 2^CNT_W.
  - The high half exposes bits CNT_W-1:32. Unused upper bits read 0 and are discarded on write.
- `mcountinhibit`:
  - Bit0 gates cycle, bit2 gates instret, bit k (3≤k<3+NUM_HPM) gates HPM k.
  - Bit1 and all unimplemented bits are hardwired 0.
- `mhpmeventK` is WARL with field width $clog2(NUM_EVENTS+1).
  - Value 0: never count.
  - Value e in 1..NUM_EVENTS: increment when `events_i[e-1]` is high.
  - Any written value > NUM_EVENTS stores 0.
- Increment conditions:
  - `mcycle`: every cycle unless inhibited.
  - `minstret`: on `instr_retired_i` unless inhibited.
  - Each HPM: by at most 1 per cycle.
- Write/increment collision on the same counter in the same cycle:
  - Write to low half: the low half takes the written value. The high half holds; the increment and its carry are lost.
  - Write to high half: the high half takes the written value. The low half increments normally; any carry out of the low half is dropped.

## Timing
- Request sampled at a rising edge. At that same edge:
  - `csr_rvalid_o` is 1 for one cycle.
  - `csr_rdata_o` holds the pre-write value, including any counting from the prior cycle.
  - The write commits.
- Back-to-back requests are accepted every cycle with no stall. A read immediately after a write returns the written value plus any increment in the cycle after the write.
- Counters are visible to reads with one-cycle latency.
- Reset values: every counter, `mhpmevent` and `mcountinhibit` is 0. `csr_rvalid_o`, `csr_rdata_o` and `csr_illegal_o` are 0.
- Reset asserted mid-operation clears all state immediately. Any in-flight response is dropped.

## Structure
- Shared package additions:
  - `CSR_ADDR_MCOUNTINHIBIT` = 320.
  - `CSR_ADDR_MHPMCOUNTER3` = B03.
  - `CSR_ADDR_MHPMCOUNTER3H` = B83.
  - `CSR_ADDR_MHPMEVENT3` = 323.
  - `CSR_OP_T_WIDTH` = 2 with `CSR_OP_READ/WRITE/SET/CLEAR`.
- Sub-module `riscv_split_counter`, instantiated NUM_HPM+2 times.
  - Parameter: `CNT_W`.
  - Inputs: `inc`, `wr_lo`, `wr_hi`, `wdata[31:0]`.
  - Output: `cnt[CNT_W-1:0]`.
  - Implements the collision rules above.
- The top level holds the decode, the op ALU, inhibit/event registers and the response register.

## Test plan
- Reset, then 10 idle cycles, then read B00: rdata 10 (±1 per the latency rule). Read B80: rdata 0. `csr_illegal_o` is 0 on both.
- Write `mcycle` 0xFFFF_FFFF, then read B80 two cycles later: rdata 1. Write B80 same cycle as low-half wrap: high half equals written value, no carry added.
- Set `mcountinhibit` 0x5: cycle and instret freeze. Clear 0x1: cycle resumes from the frozen value.
- `mhpmevent3` = 2, pulse `events_i[1]` 7 times and `events_i[0]` 3 times: B03 reads 7. Write `mhpmevent3` = 0x3F with NUM_EVENTS=8: reads back 0.
- Read 0x7C0: `csr_illegal_o` 1, rdata 0. Read B1F with NUM_HPM=4: legal, 0. Assert `rst_ni` low mid-count: all reads afterwards return 0.
